// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus (CDB) arbiter slice.
//   - src_t       : producer IDs carried on cdb_src (ALU=0, load=1, store=2)
//   - CDB_ENTRY_W : default ROB tag width
//   - payload_t   : one queued result {entry, data, aux} at the default width
//   - next_src    : successor of a source ID, modulo three
package cdb_pkg;

  localparam int CDB_ENTRY_W = 6;
  localparam int NUM_SRC     = 3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LD  = 2'd1,
    SRC_ST  = 2'd2
  } src_t;

  typedef struct packed {
    logic [CDB_ENTRY_W-1:0] entry;
    logic [31:0]            data;
    logic [31:0]            aux;
  } payload_t;

  function automatic src_t next_src(input src_t s);
    case (s)
      SRC_ALU: return SRC_LD;
      SRC_LD:  return SRC_ST;
      default: return SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cdb_if.sv
// Producer/consumer bundle of the CDB arbiter.
//   Producers : {alu,ld,st}_push/_entry/_data/_aux in, {alu,ld,st}_full back.
//   Consumers : cdb_valid/_src/_entry/_data/_aux broadcast, err_overflow flag.
// The master modport is the core side (producers and consumers together),
// the slave modport is the arbiter.
interface cdb_if #(parameter int ENTRY_W = cdb_pkg::CDB_ENTRY_W);

  logic               alu_push;
  logic [ENTRY_W-1:0] alu_entry;
  logic [31:0]        alu_data;
  logic [31:0]        alu_aux;
  logic               alu_full;

  logic               ld_push;
  logic [ENTRY_W-1:0] ld_entry;
  logic [31:0]        ld_data;
  logic [31:0]        ld_aux;
  logic               ld_full;

  logic               st_push;
  logic [ENTRY_W-1:0] st_entry;
  logic [31:0]        st_data;
  logic [31:0]        st_aux;
  logic               st_full;

  logic               cdb_valid;
  logic [1:0]         cdb_src;
  logic [ENTRY_W-1:0] cdb_entry;
  logic [31:0]        cdb_data;
  logic [31:0]        cdb_aux;
  logic               err_overflow;

  modport master (
    output alu_push, alu_entry, alu_data, alu_aux,
    output ld_push,  ld_entry,  ld_data,  ld_aux,
    output st_push,  st_entry,  st_data,  st_aux,
    input  alu_full, ld_full, st_full,
    input  cdb_valid, cdb_src, cdb_entry, cdb_data, cdb_aux, err_overflow
  );

  modport slave (
    input  alu_push, alu_entry, alu_data, alu_aux,
    input  ld_push,  ld_entry,  ld_data,  ld_aux,
    input  st_push,  st_entry,  st_data,  st_aux,
    output alu_full, ld_full, st_full,
    output cdb_valid, cdb_src, cdb_entry, cdb_data, cdb_aux, err_overflow
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-producer result queue feeding the CDB arbiter.
//   clk, rst (async, active-low), rdy (low freezes all state)
//   flush     : empties the queue and discards a same-cycle push
//   push      : enqueue push_data when not full (dropped when full)
//   pop       : dequeue the head when not empty
//   head      : oldest entry, meaningful only while !empty
//   full/empty: decoded from the registered count
module cdb_src_fifo #(
  parameter int  DEPTH     = 2,
  parameter type payload_t = cdb_pkg::payload_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     flush,
  input  logic     push,
  input  payload_t push_data,
  input  logic     pop,
  output payload_t head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  payload_t         mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = rdy && !flush && push && !full;
  assign do_pop  = rdy && !flush && pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

  // NOTE: the storage array has no reset; head is only consumed while the
  // count says the slot is occupied, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three producer FIFOs (ALU, load, store-address)
// drained one result per cycle onto a registered broadcast bus.
//   clk, rst (async, active-low), rdy (low freezes everything)
//   rollback : flush all FIFOs, drop same-cycle pushes, kill cdb_valid
//   bus      : cdb_if.slave -- producer pushes/full flags, cdb_* broadcast,
//              sticky err_overflow
// Build option: define CDB_RR_EN for round-robin arbitration; otherwise a
// fixed priority load > ALU > store is used and no pointer register exists.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int ENTRY_W    = CDB_ENTRY_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic rollback,
  cdb_if.slave bus
);

  // Same layout as cdb_pkg::payload_t, sized to this instance's tag width.
  typedef struct packed {
    logic [ENTRY_W-1:0] entry;
    logic [31:0]        data;
    logic [31:0]        aux;
  } slot_t;

  logic [NUM_SRC-1:0] push_v;
  logic [NUM_SRC-1:0] pop_v;
  logic [NUM_SRC-1:0] full_v;
  logic [NUM_SRC-1:0] empty_v;
  slot_t              push_data [NUM_SRC];
  slot_t              head      [NUM_SRC];

  assign push_v[SRC_ALU]    = bus.alu_push;
  assign push_v[SRC_LD]     = bus.ld_push;
  assign push_v[SRC_ST]     = bus.st_push;
  assign push_data[SRC_ALU] = '{entry: bus.alu_entry, data: bus.alu_data, aux: bus.alu_aux};
  assign push_data[SRC_LD]  = '{entry: bus.ld_entry,  data: bus.ld_data,  aux: bus.ld_aux};
  assign push_data[SRC_ST]  = '{entry: bus.st_entry,  data: bus.st_data,  aux: bus.st_aux};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    cdb_src_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .payload_t (slot_t)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (rollback),
      .push      (push_v[g]),
      .push_data (push_data[g]),
      .pop       (pop_v[g]),
      .head      (head[g]),
      .full      (full_v[g]),
      .empty     (empty_v[g])
    );
  end

  // Full is taken from the registered count, so it stays high in the cycle
  // the FIFO pops; producers never see a same-cycle freed slot.
  assign bus.alu_full = full_v[SRC_ALU];
  assign bus.ld_full  = full_v[SRC_LD];
  assign bus.st_full  = full_v[SRC_ST];

  // ---------------------------------------------------------------------
  // Arbitration over the FIFO heads
  // ---------------------------------------------------------------------
  logic  grant_valid;
  src_t  grant_src;
  slot_t win;

`ifdef CDB_RR_EN
  src_t rr_ptr;
  src_t cand;

  // NOTE: every signal driven here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    cand        = rr_ptr;
    // Search ptr, ptr+1, ptr+2 (mod 3); the first non-empty source wins.
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_valid && !empty_v[cand]) begin
        grant_valid = 1'b1;
        grant_src   = cand;
      end
      cand = next_src(cand);
    end
    win = head[grant_src];
  end

  // The pointer names the highest-priority source and moves just past the
  // winner; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= SRC_ALU;
    end else if (rdy) begin
      if (rollback)         rr_ptr <= SRC_ALU;
      else if (grant_valid) rr_ptr <= next_src(grant_src);
    end
  end
`else
  always_comb begin
    grant_valid = 1'b1;
    grant_src   = SRC_ALU;
    if (!empty_v[SRC_LD])       grant_src = SRC_LD;
    else if (!empty_v[SRC_ALU]) grant_src = SRC_ALU;
    else if (!empty_v[SRC_ST])  grant_src = SRC_ST;
    else                        grant_valid = 1'b0;
    win = head[grant_src];
  end
`endif

  // The FIFOs themselves ignore pop while rdy is low or a flush is active.
  assign pop_v = grant_valid ? (NUM_SRC'(1) << grant_src) : '0;

  // ---------------------------------------------------------------------
  // Registered broadcast and sticky overflow
  // ---------------------------------------------------------------------
  logic               cdb_valid;
  src_t               cdb_src;
  logic [ENTRY_W-1:0] cdb_entry;
  logic [31:0]        cdb_data;
  logic [31:0]        cdb_aux;
  logic               err_overflow;
  logic               overflow_hit;

  // A rollback discards same-cycle pushes, so those cannot overflow either.
  assign overflow_hit = |(push_v & full_v) && !rollback;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid    <= 1'b0;
      cdb_src      <= SRC_ALU;
      cdb_entry    <= '0;
      cdb_data     <= '0;
      cdb_aux      <= '0;
      err_overflow <= 1'b0;
    end else if (rdy) begin
      if (overflow_hit) err_overflow <= 1'b1;
      if (rollback) begin
        cdb_valid <= 1'b0;
      end else if (grant_valid) begin
        cdb_valid <= 1'b1;
        cdb_src   <= grant_src;
        cdb_entry <= win.entry;
        cdb_data  <= win.data;
        // Loads carry no aux value; consumers expect zero there.
        cdb_aux   <= (grant_src == SRC_LD) ? '0 : win.aux;
      end else begin
        // Idle: only valid drops, the payload registers keep their value.
        cdb_valid <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid    = cdb_valid;
  assign bus.cdb_src      = cdb_src;
  assign bus.cdb_entry    = cdb_entry;
  assign bus.cdb_data     = cdb_data;
  assign bus.cdb_aux      = cdb_aux;
  assign bus.err_overflow = err_overflow;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (FIFO_DEPTH = 2, ENTRY_W = 6).
// Inputs change 1 ns after the rising edge and outputs are checked there too.
// Define CDB_RR_EN together with the RTL to exercise round-robin mode.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clk;
  logic rst;
  logic rdy;
  logic rollback;

  int n_cmp  = 0;
  int n_fail = 0;

  cdb_if #(.ENTRY_W(6)) bus ();

  cdb_arbiter #(
    .ENTRY_W    (6),
    .FIFO_DEPTH (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cdb(input string tag, input logic [1:0] s, input logic [5:0] e,
                           input logic [31:0] d, input logic [31:0] a);
    check({tag, "_valid"}, bus.cdb_valid, 1'b1);
    check({tag, "_src"},   bus.cdb_src,   s);
    check({tag, "_entry"}, bus.cdb_entry, e);
    check({tag, "_data"},  bus.cdb_data,  d);
    check({tag, "_aux"},   bus.cdb_aux,   a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic p, input logic [5:0] e, input logic [31:0] d, input logic [31:0] a);
    bus.alu_push = p; bus.alu_entry = e; bus.alu_data = d; bus.alu_aux = a;
  endtask

  task automatic drive_ld(input logic p, input logic [5:0] e, input logic [31:0] d, input logic [31:0] a);
    bus.ld_push = p; bus.ld_entry = e; bus.ld_data = d; bus.ld_aux = a;
  endtask

  task automatic drive_st(input logic p, input logic [5:0] e, input logic [31:0] d, input logic [31:0] a);
    bus.st_push = p; bus.st_entry = e; bus.st_data = d; bus.st_aux = a;
  endtask

  task automatic clear_push();
    drive_alu(1'b0, '0, '0, '0);
    drive_ld (1'b0, '0, '0, '0);
    drive_st (1'b0, '0, '0, '0);
  endtask

  // Short reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.cdb_valid,    1'b0);
    check({tag, "_src"},   bus.cdb_src,      2'd0);
    check({tag, "_entry"}, bus.cdb_entry,    6'd0);
    check({tag, "_data"},  bus.cdb_data,     32'd0);
    check({tag, "_aux"},   bus.cdb_aux,      32'd0);
    check({tag, "_afull"}, bus.alu_full,     1'b0);
    check({tag, "_lfull"}, bus.ld_full,      1'b0);
    check({tag, "_sfull"}, bus.st_full,      1'b0);
    check({tag, "_ovf"},   bus.err_overflow, 1'b0);
  endtask

  logic [1:0] order [3];

  initial begin
    rst      = 1'b0;
    rdy      = 1'b1;
    rollback = 1'b0;
    clear_push();

    // ---------------- reset state ----------------
    #12;
    check_all_zero("reset");
    rst = 1'b1;

    // ---------------- single ALU push ----------------
    drive_alu(1'b1, 6'd5, 32'h0000_1234, 32'h80);
    step();
    clear_push();
    check("single_nobypass_valid", bus.cdb_valid, 1'b0);
    step();
    check_cdb("single", SRC_ALU, 6'd5, 32'h1234, 32'h80);
    step();
    check("single_after_valid", bus.cdb_valid, 1'b0);

    // ---------------- three-way contention ----------------
    pulse_reset();
    drive_alu(1'b1, 6'd1, 32'hA1, 32'hA2);
    drive_ld (1'b1, 6'd2, 32'hB1, 32'hB2);
    drive_st (1'b1, 6'd3, 32'hC1, 32'hC2);
    step();
    clear_push();
    check("cont_idle_valid", bus.cdb_valid, 1'b0);
`ifdef CDB_RR_EN
    order[0] = SRC_ALU; order[1] = SRC_LD; order[2] = SRC_ST;
`else
    order[0] = SRC_LD;  order[1] = SRC_ALU; order[2] = SRC_ST;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      case (order[i])
        SRC_ALU: check_cdb("cont_alu", SRC_ALU, 6'd1, 32'hA1, 32'hA2);
        SRC_LD:  check_cdb("cont_ld",  SRC_LD,  6'd2, 32'hB1, 32'h0);
        default: check_cdb("cont_st",  SRC_ST,  6'd3, 32'hC1, 32'hC2);
      endcase
    end
    step();
    check("cont_drained_valid", bus.cdb_valid, 1'b0);

    // ---------------- starvation and overflow ----------------
    pulse_reset();
`ifdef CDB_RR_EN
    drive_ld (1'b1, 6'h10, 32'h100, 32'hDEAD);
    drive_alu(1'b1, 6'h20, 32'h200, 32'h300);
    step();
    drive_alu(1'b0, '0, '0, '0);
    drive_ld (1'b1, 6'h11, 32'h101, 32'hDEAD);
    step();
    clear_push();
    check_cdb("rr_alu_first", SRC_ALU, 6'h20, 32'h200, 32'h300);
    step();
    check_cdb("rr_ld0", SRC_LD, 6'h10, 32'h100, 32'h0);
    step();
    check_cdb("rr_ld1", SRC_LD, 6'h11, 32'h101, 32'h0);
    step();
    check("rr_idle_valid", bus.cdb_valid, 1'b0);
`else
    for (int i = 0; i < 6; i++) begin
      drive_ld(1'b1, 6'(8'h10 + i), 32'h100 + i, 32'hDEAD);
      if (i < 3) drive_alu(1'b1, 6'(8'h20 + i), 32'h200 + i, 32'h300 + i);
      else       drive_alu(1'b0, '0, '0, '0);
      step();
      if (i == 1) begin
        check("starve_alu_full", bus.alu_full, 1'b1);
        check("starve_no_ovf_yet", bus.err_overflow, 1'b0);
      end
      if (i == 2) check("starve_overflow", bus.err_overflow, 1'b1);
      if (i >= 1) check_cdb("starve_ld", SRC_LD, 6'(8'h10 + i - 1), 32'h100 + i - 1, 32'h0);
    end
    clear_push();
    step();
    check_cdb("starve_ld_last", SRC_LD, 6'h15, 32'h105, 32'h0);
    check("starve_full_while_pop", bus.alu_full, 1'b1);
    step();
    check_cdb("starve_alu0", SRC_ALU, 6'h20, 32'h200, 32'h300);
    check("starve_alu_not_full", bus.alu_full, 1'b0);
    step();
    check_cdb("starve_alu1", SRC_ALU, 6'h21, 32'h201, 32'h301);
    step();
    check("starve_dropped_valid", bus.cdb_valid, 1'b0);
`endif

    // ---------------- rollback ----------------
    pulse_reset();
    drive_alu(1'b1, 6'h31, 32'h310, 32'h311);
    drive_ld (1'b1, 6'h32, 32'h320, 32'h321);
    drive_st (1'b1, 6'h33, 32'h330, 32'h331);
    step();
    drive_alu(1'b1, 6'h34, 32'h340, 32'h341);
    drive_ld (1'b1, 6'h35, 32'h350, 32'h351);
    drive_st (1'b1, 6'h36, 32'h360, 32'h361);
    step();
    clear_push();
    check("rb_st_full", bus.st_full, 1'b1);
    check("rb_ovf_clear", bus.err_overflow, 1'b0);
    drive_st(1'b1, 6'h37, 32'h370, 32'h371);
    step();
    clear_push();
    check("rb_ovf_set", bus.err_overflow, 1'b1);
    rollback = 1'b1;
    drive_alu(1'b1, 6'h38, 32'h380, 32'h381);
    step();
    rollback = 1'b0;
    clear_push();
    check("rb_valid", bus.cdb_valid, 1'b0);
    check("rb_afull", bus.alu_full, 1'b0);
    check("rb_lfull", bus.ld_full, 1'b0);
    check("rb_sfull", bus.st_full, 1'b0);
    check("rb_ovf_kept", bus.err_overflow, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rb_quiet_valid", bus.cdb_valid, 1'b0);
    end

    // ---------------- rdy low mid-stream ----------------
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 6'(8'h3A + i), 32'h400 + i, 32'h500 + i);
      step();
      if (i == 0) check("rdy_first_valid", bus.cdb_valid, 1'b0);
      if (i >= 1) check_cdb("rdy_stream", SRC_ALU, 6'(8'h3A + i - 1), 32'h400 + i - 1, 32'h500 + i - 1);
    end
    rdy = 1'b0;
    drive_alu(1'b1, 6'h3F, 32'h999, 32'h999);
    for (int i = 0; i < 3; i++) begin
      step();
      check_cdb("rdy_frozen", SRC_ALU, 6'h3B, 32'h401, 32'h501);
      check("rdy_frozen_full", bus.alu_full, 1'b0);
    end
    rdy = 1'b1;
    clear_push();
    step();
    check_cdb("rdy_resume", SRC_ALU, 6'h3C, 32'h402, 32'h502);
    step();
    check("rdy_done_valid", bus.cdb_valid, 1'b0);

    // ---------------- reset mid-operation ----------------
    drive_alu(1'b1, 6'h11, 32'h1111, 32'h1112);
    drive_ld (1'b1, 6'h12, 32'h2221, 32'h2222);
    drive_st (1'b1, 6'h13, 32'h3331, 32'h3332);
    step();
    clear_push();
    step();
    check("mid_pre_valid", bus.cdb_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_async");
    #2;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("mid_empty_valid", bus.cdb_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
